uart_rx: RTL and testbench

UART receiver, 8N1 framing by default: 1 start bit, 8 data bits LSB first, 1 stop bit. It is the receive-side counterpart of the bus UART transmitter.
- Oversamples the asynchronous serial line with the system clock and samples each bit at mid-bit.
- Presents each good byte with a one-cycle valid pulse and flags framing errors.
- Sits between the board RX pin and the bus-side slave/bridge logic.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_sync.sv | 26 ++
 rtl/uart_rx.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame geometry and default bit timing.
// Used by both the receiver and the transmitter.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 87;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4,
    PARITY  = 3'd5
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input. Both flops reset to 1 so an
// idle-high serial line does not look like a start bit coming out of reset.
module uart_rx_sync (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Async,
  output logic o_Sync
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the async input.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= i_Async;
      sync_q <= meta_q;
    end
  end

  assign o_Sync = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default. Samples each bit at mid-bit using the system
// clock as oversampling reference. Define UART_RX_PARITY_EN to add a parity bit
// between data and stop (even parity unless PARITY_ODD=1) and o_Rx_Parity_Err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Active,
  output logic       o_Rx_Frame_Err
`ifdef UART_RX_PARITY_EN
  , output logic     o_Rx_Parity_Err
`endif
);

  localparam logic [7:0] HALF_CNT = 8'((CLKS_PER_BIT - 1) / 2);
  localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic        rx_s;
  uart_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  byte_q, byte_d;
  logic        dv_q, dv_d;
  logic        ferr_q, ferr_d;
  logic        active_q, active_d;
`ifdef UART_RX_PARITY_EN
  logic        par_q, par_d;
  logic        perr_q, perr_d;
`endif

  uart_rx_sync u_sync (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Async (i_Rx_Serial),
    .o_Sync  (rx_s)
  );

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      byte_q   <= 8'h00;
      dv_q     <= 1'b0;
      ferr_q   <= 1'b0;
      active_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q    <= 1'b0;
      perr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      dv_q     <= dv_d;
      ferr_q   <= ferr_d;
      active_q <= active_d;
`ifdef UART_RX_PARITY_EN
      par_q    <= par_d;
      perr_q   <= perr_d;
`endif
    end
  end

  // Frame sequencing: next state, counters and one-cycle output pulses.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    dv_d     = 1'b0;
    ferr_d   = 1'b0;
    active_d = active_q;
`ifdef UART_RX_PARITY_EN
    par_d    = par_q;
    perr_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d    = 8'd0;
        bit_d    = 3'd0;
        active_d = 1'b0;
        if (!rx_s) begin
          state_d  = START;
          active_d = 1'b1;
        end
      end
      START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d = 8'd0;
          if (!rx_s) begin
            state_d = DATA;
          end else begin
            // Line went back high before mid start bit: treat as a glitch.
            state_d  = IDLE;
            active_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d          = 8'd0;
          shift_d[bit_q] = rx_s;
          if (bit_q == LAST_BIT) begin
            bit_d = 3'd0;
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = 8'd0;
          par_d   = rx_s;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`endif
      STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d    = 8'd0;
          state_d  = CLEANUP;
          active_d = 1'b0;
          if (rx_s) begin
            byte_d = shift_q;
            dv_d   = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          perr_d = ((^shift_q) ^ par_q) != PARITY_ODD;
`endif
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      CLEANUP: begin
        active_d = 1'b0;
        // Hold here while the line is low so a break cannot start a new frame.
        if (rx_s) state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = 8'd0;
        bit_d    = 3'd0;
        active_d = 1'b0;
      end
    endcase
  end

  assign o_Rx_DV        = dv_q;
  assign o_Rx_Byte      = byte_q;
  assign o_Rx_Active    = active_q;
  assign o_Rx_Frame_Err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign o_Rx_Parity_Err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=8 with a byte scoreboard.
// Define UART_RX_PARITY_EN to build against the parity variant.
module tb_uart_rx;

  localparam int C    = 8;
  localparam int HALF = (C - 1) / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NOM  = 4 + HALF + 10 * C;
`else
  localparam int NOM  = 4 + HALF + 9 * C;
`endif

  typedef struct {
    logic [7:0] data;
    int         t0;
    logic       perr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       dv;
  logic [7:0] rbyte;
  logic       active;
  logic       ferr;
`ifdef UART_RX_PARITY_EN
  logic       perr;
`endif

  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_dv  = 0;
  int   n_ferr = 0;
  logic [7:0] last_byte = 8'h00;
  exp_t exp_q[$];

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .i_Clock        (clk),
    .i_Reset        (rst),
    .i_Rx_Serial    (rx),
    .o_Rx_DV        (dv),
    .o_Rx_Byte      (rbyte),
    .o_Rx_Active    (active),
    .o_Rx_Frame_Err (ferr)
`ifdef UART_RX_PARITY_EN
    , .o_Rx_Parity_Err (perr)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every DV pulse must match the oldest queued frame.
  always @(negedge clk) begin
    if (rst) begin
      last_byte = 8'h00;
    end else begin
      if (dv) begin
        exp_t e;
        n_dv++;
        chk("dv_expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("rx_byte", rbyte, e.data);
          chk("latency_ok", ((cyc - e.t0) >= NOM - 1) && ((cyc - e.t0) <= NOM + 1), 1);
`ifdef UART_RX_PARITY_EN
          chk("parity_err", perr, e.perr);
`endif
        end
        last_byte = rbyte;
      end
      if (ferr) begin
        n_ferr++;
        chk("ferr_byte_kept", rbyte, last_byte);
        chk("ferr_not_dv", dv, 0);
      end
    end
  end

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (C) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop_b, input logic push, input logic bad_par);
    exp_t e;
    e.data = b;
    e.t0   = cyc;
    e.perr = bad_par;
    if (push) exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ bad_par);
`endif
    drive_bit(stop_b);
  endtask

  initial begin
    int dv0;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dv", dv, 0);
    chk("rst_byte", rbyte, 8'h00);
    chk("rst_active", active, 0);
    chk("rst_ferr", ferr, 0);
    rst = 1'b0;
    idle(2 * C);

    // Single frame
    send(8'hA5, 1'b1, 1'b1, 1'b0);
    idle(2 * C);
    chk("a5_dv_count", n_dv, 1);
    chk("a5_byte", rbyte, 8'hA5);
    chk("a5_no_ferr", n_ferr, 0);
    chk("a5_active_low", active, 0);

    // Back-to-back frames, no idle gap
    send(8'h00, 1'b1, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b1, 1'b0);
    send(8'h55, 1'b1, 1'b1, 1'b0);
    idle(2 * C);
    chk("b2b_dv_count", n_dv, 4);
    chk("b2b_last_byte", rbyte, 8'h55);

    // Short low glitch on idle line
    rx = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("glitch_active_seen", active, 1);
    idle(2 * C);
    chk("glitch_active_low", active, 0);
    chk("glitch_no_dv", n_dv, 4);
    chk("glitch_no_ferr", n_ferr, 0);

    // Framing error followed by a long break
    send(8'h3C, 1'b0, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (15 * C) @(posedge clk);
    #1;
    chk("break_active_low", active, 0);
    chk("break_ferr_count", n_ferr, 1);
    repeat (15 * C) @(posedge clk);
    #1;
    chk("break_no_dv", n_dv, 4);
    chk("break_ferr_once", n_ferr, 1);
    chk("break_byte_kept", rbyte, 8'h55);
    idle(2 * C);
    send(8'h81, 1'b1, 1'b1, 1'b0);
    idle(2 * C);
    chk("after_break_dv", n_dv, 5);
    chk("after_break_byte", rbyte, 8'h81);

    // Reset in the middle of data bits of 8'hC3
    dv0 = n_dv;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    chk("mid_active", active, 1);
    rst = 1'b1;
    rx  = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_dv", dv, 0);
    chk("mrst_byte", rbyte, 8'h00);
    chk("mrst_active", active, 0);
    chk("mrst_ferr", ferr, 0);
    rst = 1'b0;
    idle(10 * C);
    chk("mrst_no_dv", n_dv, dv0);
    send(8'h12, 1'b1, 1'b1, 1'b0);
    idle(2 * C);
    chk("post_rst_dv", n_dv, dv0 + 1);
    chk("post_rst_byte", rbyte, 8'h12);

`ifdef UART_RX_PARITY_EN
    // Parity: wrong then correct
    send(8'h07, 1'b1, 1'b1, 1'b1);
    idle(2 * C);
    send(8'h07, 1'b1, 1'b1, 1'b0);
    idle(2 * C);
    chk("par_dv_count", n_dv, dv0 + 3);
    chk("par_byte", rbyte, 8'h07);
`endif

    chk("queue_empty", exp_q.size(), 0);
    chk("total_ferr", n_ferr, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
